pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Match controller that sequences the ball datapath for the Pong game. It runs the serve/rally/point/game-over state machine, generates the ball's `move_tick` step strobe from a programmable period, and shortens that period as rallies lengthen. It detects misses from the ball's x position, keeps both scores, and picks the serve direction. It sits between the paddle and ball logic and the score display.

## Interface
Parameters:
- `ACTIVE_COLS`, 640, visible columns.
- `SIDE_LEN`, 16, ball side length in pixels.
- `CLKS_PER_MOVE_INIT`, 5_000_000, move period in clocks at serve.
- `CLKS_PER_MOVE_MIN`, 1_000_000, floor for the move period.
- `SPEEDUP_STEP`, 500_000, clocks removed from the period per speed-up.
- `HITS_PER_SPEEDUP`, 4, paddle hits per speed-up.
- `SERVE_DELAY`, 50_000_000, clocks spent in SERVE.
- `WIN_SCORE`, 7, points needed to win.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse, already synchronised to `clk`.
- `ball_x`  in  $clog2(ACTIVE_COLS)  ball left-edge column.
- `paddle_hit`  in  1  single-cycle pulse when the ball bounces off either paddle.
- `move_tick`  out  1  single-cycle strobe; the ball steps one pixel on it.
- `ball_recenter`  out  1  holds the ball at the centre while high.
- `serve_left`  out  1  serve direction; 1 = serve toward player 1 (left).
- `score1`, `score2`  out  $clog2(WIN_SCORE+1) each  player scores.
- `game_over`  out  1  high in OVER.
- `winner`  out  1  0 = player 1, 1 = player 2; valid while `game_over` is high.

## Operation
- States: IDLE, SERVE, RALLY, POINT, OVER.
- IDLE:
  - `start` → SERVE.
  - Scores 0; `serve_left` = 0.
- SERVE:
  - Delay counter runs exactly `SERVE_DELAY` cycles, then → RALLY.
  - On entry, `move_period` loads `CLKS_PER_MOVE_INIT` and the hit count clears.
- RALLY:
  - Tick counter increments every cycle.
  - When the count is ≥ `move_period`-1, `move_tick` pulses and the counter clears.
  - Because the compare is ≥, shortening the period mid-count never skips or delays a tick beyond the new period.
- Miss detection, evaluated only in RALLY:
  - `ball_x == 0` is a left miss: `score2`++, `serve_left` ← 1.
  - `ball_x >= ACTIVE_COLS-SIDE_LEN` is a right miss: `score1`++, `serve_left` ← 0.
  - Either miss → POINT.
- Speed-up:
  - `paddle_hit` in RALLY increments the hit count.
  - When the count reaches `HITS_PER_SPEEDUP`, it clears and `move_period` ← max(`CLKS_PER_MOVE_MIN`, `move_period` − `SPEEDUP_STEP`).
  - The subtraction is done without underflow: compare first, then subtract.
- POINT (one cycle):
  - If the updated scorer's score equals `WIN_SCORE` → OVER, with `winner` set to the scorer.
  - Otherwise → SERVE.
- OVER:
  - Scores hold.
  - `start` clears both scores and `serve_left`, then → SERVE.
- Simultaneous events:
  - Miss and `paddle_hit` in the same cycle: the miss wins and the hit is ignored.
  - `start` is ignored in SERVE, RALLY and POINT.
  - `paddle_hit` is ignored outside RALLY.
- `ball_recenter` is high in every state except RALLY.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `move_tick` 0
  - `ball_recenter` 1
  - `serve_left` 0
  - `score1`/`score2` 0
  - `game_over` 0
  - `winner` 0
  - `move_period` `CLKS_PER_MOVE_INIT`
- `rst` asserted at any time, including mid-rally, forces all of these immediately without waiting for a clock edge.
- `start` sampled at edge N: state SERVE and `ball_recenter` high from N+1; RALLY entered at N+1+`SERVE_DELAY`.
- `ball_recenter` falls on the RALLY entry edge.
- First `move_tick` comes `move_period` cycles after RALLY entry; subsequent ticks are exactly `move_period` apart.
- Miss seen at edge M:
  - score, `serve_left` and POINT all update at M+1.
  - `ball_recenter` is high and `move_tick` is 0 from M+1.
  - SERVE or OVER at M+2; `game_over` rises at M+2.
- A speed-up takes effect on the edge after the triggering hit.

## Structure
- `pong_pkg` holds:
  - the `game_state_t` enum (IDLE, SERVE, RALLY, POINT, OVER);
  - a score-width helper function;
  - the shared `ACTIVE_COLS`/`SIDE_LEN` defaults.
- One sub-module, `move_tick_gen`:
  - a programmable-period strobe generator with inputs `enable`, `clear`, `period`;
  - `enable` = in RALLY; `clear` = on SERVE entry.
- The FSM, scores and speed logic stay in `pong_game_ctrl`.

## Test plan
Bench parameters: `SERVE_DELAY`=10, `CLKS_PER_MOVE_INIT`=8, `CLKS_PER_MOVE_MIN`=4, `SPEEDUP_STEP`=2, `HITS_PER_SPEEDUP`=4, `WIN_SCORE`=3, `ball_x`=320.
- Reset, `start` pulse → `ball_recenter` high 10 cycles; first `move_tick` 8 cycles after RALLY entry; then one tick every 8 cycles.
- 4 `paddle_hit` pulses → period 6. 8 more → period 4. 4 more → period stays 4; tick spacing matches each period.
- In RALLY, `ball_x`=0 → `score2`=1, `serve_left`=1, `ball_recenter` high next cycle. After the next SERVE, period is back to 8.
- `paddle_hit` and `ball_x`=624 in the same cycle → `score1`=1, hit count unchanged; no speed-up after 3 further hits.
- Player 1 scores 3 times → `game_over`=1, `winner`=0, no ticks. `start` → scores 0, SERVE.
- `rst` pulsed mid-RALLY between clock edges → all outputs at reset values immediately; state IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types, defaults and helpers for the Pong match controller.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    RALLY,
    POINT,
    OVER
  } game_state_t;

  localparam int ACTIVE_COLS_DEF = 640;
  localparam int SIDE_LEN_DEF    = 16;

  // Bits needed to hold a score from 0 up to and including the winning score.
  function automatic int score_width(input int win_score);
    return $clog2(win_score + 1);
  endfunction

endpackage

// File: rtl/pong_game_ctrl_move_tick_gen.sv
// Programmable-period strobe generator that paces the ball's one-pixel steps.
module move_tick_gen
  import pong_pkg::*;
#(
  parameter int PERIOD_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;

  // The >= compare lets a period that shrinks mid-count fire on the next edge
  // instead of wrapping the counter and missing the new, shorter deadline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      if (count >= period - 1'b1) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Match controller: serve/rally/point/game-over sequencing, scoring and ball speed-up.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int ACTIVE_COLS        = ACTIVE_COLS_DEF,
  parameter int SIDE_LEN           = SIDE_LEN_DEF,
  parameter int CLKS_PER_MOVE_INIT = 5_000_000,
  parameter int CLKS_PER_MOVE_MIN  = 1_000_000,
  parameter int SPEEDUP_STEP       = 500_000,
  parameter int HITS_PER_SPEEDUP   = 4,
  parameter int SERVE_DELAY        = 50_000_000,
  parameter int WIN_SCORE          = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(ACTIVE_COLS)-1:0]    ball_x,
  input  logic                              paddle_hit,
  output logic                              move_tick,
  output logic                              ball_recenter,
  output logic                              serve_left,
  output logic [score_width(WIN_SCORE)-1:0] score1,
  output logic [score_width(WIN_SCORE)-1:0] score2,
  output logic                              game_over,
  output logic                              winner
);

  localparam int X_W        = $clog2(ACTIVE_COLS);
  localparam int SCORE_W    = score_width(WIN_SCORE);
  localparam int PERIOD_MAX = (CLKS_PER_MOVE_INIT > CLKS_PER_MOVE_MIN + SPEEDUP_STEP) ?
                              CLKS_PER_MOVE_INIT : CLKS_PER_MOVE_MIN + SPEEDUP_STEP;
  localparam int PERIOD_W   = $clog2(PERIOD_MAX + 1);
  localparam int HIT_W      = $clog2(HITS_PER_SPEEDUP + 1);
  localparam int SERVE_W    = $clog2(SERVE_DELAY + 1);

  localparam logic [X_W-1:0]      RIGHT_EDGE    = X_W'(ACTIVE_COLS - SIDE_LEN);
  localparam logic [SCORE_W-1:0]  WIN_V         = SCORE_W'(WIN_SCORE);
  localparam logic [PERIOD_W-1:0] PERIOD_INIT   = PERIOD_W'(CLKS_PER_MOVE_INIT);
  localparam logic [PERIOD_W-1:0] PERIOD_MIN    = PERIOD_W'(CLKS_PER_MOVE_MIN);
  localparam logic [PERIOD_W-1:0] PERIOD_STEP   = PERIOD_W'(SPEEDUP_STEP);
  localparam logic [PERIOD_W-1:0] SPEEDUP_LIMIT = PERIOD_W'(CLKS_PER_MOVE_MIN + SPEEDUP_STEP);
  localparam logic [HIT_W-1:0]    HIT_LAST      = HIT_W'(HITS_PER_SPEEDUP - 1);
  localparam logic [SERVE_W-1:0]  SERVE_LAST    = SERVE_W'(SERVE_DELAY - 1);

  game_state_t         state;
  logic [PERIOD_W-1:0] move_period;
  logic [HIT_W-1:0]    hit_count;
  logic [SERVE_W-1:0]  serve_cnt;

  logic miss_left, miss_right, point_won, serve_entry, tick_enable;

  assign miss_left   = (state == RALLY) && (ball_x == '0);
  assign miss_right  = (state == RALLY) && (ball_x >= RIGHT_EDGE);
  // serve_left doubles as "player 2 took the last point" while in POINT
  assign point_won   = serve_left ? (score2 == WIN_V) : (score1 == WIN_V);
  assign serve_entry = (((state == IDLE) || (state == OVER)) && start) ||
                       ((state == POINT) && !point_won);
  assign tick_enable = (state == RALLY) && !(miss_left || miss_right);

  move_tick_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_move_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(tick_enable),
    .clear (serve_entry),
    .period(move_period),
    .tick  (move_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ball_recenter <= 1'b1;
      serve_left    <= 1'b0;
      score1        <= '0;
      score2        <= '0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      move_period   <= PERIOD_INIT;
      hit_count     <= '0;
      serve_cnt     <= '0;
    end else begin
      if (serve_entry) begin
        state         <= SERVE;
        serve_cnt     <= '0;
        move_period   <= PERIOD_INIT;
        hit_count     <= '0;
        ball_recenter <= 1'b1;
        game_over     <= 1'b0;
      end
      case (state)
        IDLE: begin
          score1     <= '0;
          score2     <= '0;
          serve_left <= 1'b0;
        end
        SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            state         <= RALLY;
            ball_recenter <= 1'b0;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end
        RALLY: begin
          if (miss_left) begin
            score2        <= score2 + 1'b1;
            serve_left    <= 1'b1;
            state         <= POINT;
            ball_recenter <= 1'b1;
          end else if (miss_right) begin
            score1        <= score1 + 1'b1;
            serve_left    <= 1'b0;
            state         <= POINT;
            ball_recenter <= 1'b1;
          end else if (paddle_hit) begin
            if (hit_count == HIT_LAST) begin
              hit_count   <= '0;
              move_period <= (move_period >= SPEEDUP_LIMIT) ? move_period - PERIOD_STEP
                                                            : PERIOD_MIN;
            end else begin
              hit_count <= hit_count + 1'b1;
            end
          end
        end
        POINT: begin
          if (point_won) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= serve_left;
          end
        end
        OVER: begin
          if (start) begin
            score1     <= '0;
            score2     <= '0;
            serve_left <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          ball_recenter <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: tick-timing scoreboard plus scoring and reset checks.
module tb_pong_game_ctrl;

  localparam int SERVE_DELAY = 10;
  localparam int P_INIT      = 8;
  localparam int P_MIN       = 4;
  localparam int P_STEP      = 2;
  localparam int HITS        = 4;
  localparam int WIN         = 3;
  localparam logic [9:0] CENTRE_X = 10'd320;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] ball_x;
  logic       paddle_hit;
  logic       move_tick, ball_recenter, serve_left, game_over, winner;
  logic [1:0] score1, score2;

  int cyc = 0;
  int n_compared = 0;
  int n_mismatched = 0;
  int exp_ticks[$];
  int next_tick, model_period, model_hits;

  pong_game_ctrl #(
    .ACTIVE_COLS       (640),
    .SIDE_LEN          (16),
    .CLKS_PER_MOVE_INIT(P_INIT),
    .CLKS_PER_MOVE_MIN (P_MIN),
    .SPEEDUP_STEP      (P_STEP),
    .HITS_PER_SPEEDUP  (HITS),
    .SERVE_DELAY       (SERVE_DELAY),
    .WIN_SCORE         (WIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ball_x       (ball_x),
    .paddle_hit   (paddle_hit),
    .move_tick    (move_tick),
    .ball_recenter(ball_recenter),
    .serve_left   (serve_left),
    .score1       (score1),
    .score2       (score2),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Drives one cycle of inputs at a falling edge, then returns them to idle values.
  task automatic applyStimulus(input logic st, input logic hit, input logic [9:0] bx);
    start      = st;
    paddle_hit = hit;
    ball_x     = bx;
    @(negedge clk);
    start      = 1'b0;
    paddle_hit = 1'b0;
    ball_x     = CENTRE_X;
  endtask

  // Tick scoreboard: every expected tick edge is pushed ahead of time and matched here.
  always @(negedge clk) begin
    if (exp_ticks.size() != 0 && cyc == exp_ticks[0]) begin
      checkOutput("tick_at_expected", move_tick, 1);
      void'(exp_ticks.pop_front());
    end else if (move_tick) begin
      checkOutput("tick_unexpected", cyc, (exp_ticks.size() != 0) ? exp_ticks[0] : -1);
    end
  end

  task automatic expect_serve(input int s_edge);
    int n;
    while (cyc < s_edge) @(negedge clk);
    n = 0;
    while (ball_recenter && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("serve_cycles", n, SERVE_DELAY);
    model_period = P_INIT;
    model_hits   = 0;
    next_tick    = s_edge + SERVE_DELAY + P_INIT;
  endtask

  task automatic run_interval(input bit hit);
    exp_ticks.push_back(next_tick);
    while (cyc < next_tick) @(negedge clk);
    if (hit) begin
      applyStimulus(1'b0, 1'b1, CENTRE_X);
      model_hits++;
      if (model_hits == HITS) begin
        model_hits   = 0;
        model_period = (model_period - P_STEP < P_MIN) ? P_MIN : model_period - P_STEP;
      end
    end
    next_tick += model_period;
  endtask

  task automatic do_miss(input bit left, input bit hit, input int exp_s1, input int exp_s2);
    applyStimulus(1'b0, hit, left ? 10'd0 : 10'd624);
    checkOutput("miss_score1", score1, exp_s1);
    checkOutput("miss_score2", score2, exp_s2);
    checkOutput("miss_serve_left", serve_left, int'(left));
    checkOutput("miss_recenter", ball_recenter, 1);
    checkOutput("miss_tick", move_tick, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, compared %0d", n_compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, n;
    rst = 1'b1; start = 1'b0; paddle_hit = 1'b0; ball_x = CENTRE_X;
    #3;
    checkOutput("rst_move_tick", move_tick, 0);
    checkOutput("rst_recenter", ball_recenter, 1);
    checkOutput("rst_serve_left", serve_left, 0);
    checkOutput("rst_score1", score1, 0);
    checkOutput("rst_score2", score2, 0);
    checkOutput("rst_game_over", game_over, 0);
    checkOutput("rst_winner", winner, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] first serve and base tick spacing");
    s = cyc + 1;
    applyStimulus(1'b1, 1'b0, CENTRE_X);
    expect_serve(s);
    repeat (3) run_interval(1'b0);

    $display("[TB] speed-up: 16 hits, period 8 -> 6 -> 4 -> 4 -> 4");
    repeat (16) run_interval(1'b1);
    repeat (2) run_interval(1'b0);

    $display("[TB] left miss, period restored on serve");
    do_miss(1'b1, 1'b0, 0, 1);
    expect_serve(cyc + 1);
    repeat (2) run_interval(1'b0);

    $display("[TB] hit and right miss together");
    do_miss(1'b0, 1'b1, 1, 1);
    expect_serve(cyc + 1);
    repeat (3) run_interval(1'b1);
    repeat (2) run_interval(1'b0);

    $display("[TB] player 1 wins");
    do_miss(1'b0, 1'b0, 2, 1);
    expect_serve(cyc + 1);
    do_miss(1'b0, 1'b0, 3, 1);
    @(negedge clk);
    checkOutput("over_game_over", game_over, 1);
    checkOutput("over_winner", winner, 0);
    checkOutput("over_recenter", ball_recenter, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (move_tick) n++;
    end
    checkOutput("over_ticks", n, 0);
    checkOutput("over_score1", score1, 3);
    checkOutput("over_score2", score2, 1);
    s = cyc + 1;
    applyStimulus(1'b1, 1'b0, CENTRE_X);
    checkOutput("restart_score1", score1, 0);
    checkOutput("restart_score2", score2, 0);
    checkOutput("restart_game_over", game_over, 0);
    checkOutput("restart_serve_left", serve_left, 0);
    expect_serve(s);

    $display("[TB] asynchronous reset mid-rally");
    do_miss(1'b1, 1'b0, 0, 1);
    expect_serve(cyc + 1);
    run_interval(1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_move_tick", move_tick, 0);
    checkOutput("arst_recenter", ball_recenter, 1);
    checkOutput("arst_serve_left", serve_left, 0);
    checkOutput("arst_score1", score1, 0);
    checkOutput("arst_score2", score2, 0);
    checkOutput("arst_game_over", game_over, 0);
    checkOutput("arst_winner", winner, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (ball_recenter) n++;
    end
    checkOutput("idle_recenter_cycles", n, 30);
    s = cyc + 1;
    applyStimulus(1'b1, 1'b0, CENTRE_X);
    expect_serve(s);
    run_interval(1'b0);
    @(negedge clk);
    checkOutput("ticks_outstanding", exp_ticks.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
